// File: rtl/wb_pwm_multi_if.sv
// Wishbone classic slave bundle for the multi-channel PWM block.
// A request is valid while cyc & stb are high; the slave accepts it by pulsing ack for one cycle.
interface wb_pwm_multi_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_pwm_multi.sv
// Wishbone-slave PWM generator: shared prescaler and period counter, per-channel
// duty/enable/polarity, shadow registers applied atomically at period wrap.
module wb_pwm_multi #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  wb_pwm_multi_if.slave   wb,
  output logic [N_CH-1:0] pwm_o,
  output logic            irq
);

  logic             ack_q;
  logic [31:0]      dat_q;
  logic             gen, ie, wrap;
  logic [CNT_W-1:0] period_sh, period_act, cnt;
  logic [PRE_W-1:0] prescale, pre_cnt;
  logic [N_CH-1:0]  ch_en, pol, pwm_q;
  logic [CNT_W-1:0] duty_sh  [N_CH];
  logic [CNT_W-1:0] duty_act [N_CH];

  logic        req, wr, tick, wrap_evt, pend;
  logic [5:0]  word;
  logic [31:0] rdata;
  logic [15:0] cnt_lo;
  logic        unused_adr;

  // A new request is only taken while ack is low, so ack can never be high two cycles running.
  assign req        = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr         = req & wb.wb_we_i;
  assign word       = wb.wb_adr_i[7:2];
  assign unused_adr = ^{wb.wb_adr_i[31:8], wb.wb_adr_i[1:0]};
  assign tick       = gen & (pre_cnt == prescale);
  assign wrap_evt   = tick & (cnt == period_act);
  assign cnt_lo     = 16'(cnt);

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign pwm_o       = pwm_q;
  assign irq         = wrap & ie;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    pend = (period_sh != period_act);
    for (int i = 0; i < N_CH; i++)
      if (duty_sh[i] != duty_act[i]) pend = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (word)
      6'h00: rdata = {30'b0, ie, gen};
      6'h01: rdata = 32'(period_sh);
      6'h02: rdata = 32'(prescale);
      6'h03: rdata = {cnt_lo, 14'b0, pend, wrap};
      6'h04: rdata = 32'(ch_en);
      6'h05: rdata = 32'(pol);
      default: begin
        for (int i = 0; i < N_CH; i++)
          if (word == 6'(8 + i)) rdata = 32'(duty_sh[i]);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      if (req) dat_q <= rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gen       <= 1'b0;
      ie        <= 1'b0;
      period_sh <= '0;
      prescale  <= '0;
      ch_en     <= '0;
      pol       <= '0;
      for (int i = 0; i < N_CH; i++) duty_sh[i] <= '0;
    end else if (wr) begin
      case (word)
        6'h00: {ie, gen} <= 2'(merge({30'b0, ie, gen}, wb.wb_dat_i, wb.wb_sel_i));
        6'h01: period_sh <= CNT_W'(merge(32'(period_sh), wb.wb_dat_i, wb.wb_sel_i));
        6'h02: prescale  <= PRE_W'(merge(32'(prescale), wb.wb_dat_i, wb.wb_sel_i));
        6'h04: ch_en     <= N_CH'(merge(32'(ch_en), wb.wb_dat_i, wb.wb_sel_i));
        6'h05: pol       <= N_CH'(merge(32'(pol), wb.wb_dat_i, wb.wb_sel_i));
        default: begin
          for (int i = 0; i < N_CH; i++)
            if (word == 6'(8 + i))
              duty_sh[i] <= CNT_W'(merge(32'(duty_sh[i]), wb.wb_dat_i, wb.wb_sel_i));
        end
      endcase
    end
  end

  // Actives track the shadows while idle and only reload at a wrap while running,
  // so a duty/period change never produces a truncated or stretched pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt    <= '0;
      cnt        <= '0;
      period_act <= '0;
      wrap       <= 1'b0;
      for (int i = 0; i < N_CH; i++) duty_act[i] <= '0;
    end else begin
      if (!gen) begin
        pre_cnt    <= '0;
        cnt        <= '0;
        period_act <= period_sh;
        for (int i = 0; i < N_CH; i++) duty_act[i] <= duty_sh[i];
      end else if (tick) begin
        pre_cnt <= '0;
        if (cnt == period_act) begin
          cnt        <= '0;
          period_act <= period_sh;
          for (int i = 0; i < N_CH; i++) duty_act[i] <= duty_sh[i];
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
      if (wrap_evt)
        wrap <= 1'b1;
      else if (wr && word == 6'h03 && wb.wb_sel_i[0] && wb.wb_dat_i[0])
        wrap <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++)
        pwm_q[i] <= (gen & ch_en[i] & (cnt < duty_act[i])) ^ pol[i];
    end
  end

endmodule

// File: tb/tb_wb_pwm_multi.sv
// Bench for wb_pwm_multi: phase-based reference model checked every cycle,
// plus directed register/waveform scenarios with hand-derived expectations.
`timescale 1ns/1ps
module tb_wb_pwm_multi;
  localparam int N_CH = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] pwm_o;
  logic            irq;

  wb_pwm_multi_if bus();

  wb_pwm_multi #(.N_CH(N_CH), .CNT_W(16), .PRE_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .wb    (bus),
    .pwm_o (pwm_o),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // The running generator is described by its phase m_p: clocks elapsed in the
  // current period of (PERIOD+1)*(PRESCALE+1) clocks; counter value is m_p/(PRESCALE+1).
  bit              m_gen, m_ie, m_wrap;
  logic [15:0]     m_per_sh, m_per_act;
  logic [7:0]      m_pre, m_ch_en, m_pol;
  logic [15:0]     m_duty_sh  [N_CH];
  logic [15:0]     m_duty_act [N_CH];
  longint          m_p;
  int              m_wraps = 0;
  bit              p_valid;
  logic [31:0]     p_addr, p_dat;
  logic [3:0]      p_sel;
  logic [N_CH-1:0] exp_pwm;

  function automatic void model_reset();
    m_gen = 0; m_ie = 0; m_wrap = 0;
    m_per_sh = 0; m_per_act = 0; m_pre = 0; m_ch_en = 0; m_pol = 0;
    for (int i = 0; i < N_CH; i++) begin m_duty_sh[i] = 0; m_duty_act[i] = 0; end
    m_p = 0;
    p_valid = 0;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  function automatic void model_apply(input bit wrapped);
    int w;
    logic [31:0] t;
    w = int'(p_addr[7:2]);
    case (w)
      0: begin
        t = lane_merge({30'b0, m_ie, m_gen}, p_dat, p_sel);
        m_gen = t[0]; m_ie = t[1];
      end
      1: m_per_sh = 16'(lane_merge(32'(m_per_sh), p_dat, p_sel));
      2: m_pre    = 8'(lane_merge(32'(m_pre), p_dat, p_sel));
      3: if (p_sel[0] && p_dat[0] && !wrapped) m_wrap = 0;
      4: m_ch_en  = 8'(lane_merge(32'(m_ch_en), p_dat, p_sel));
      5: m_pol    = 8'(lane_merge(32'(m_pol), p_dat, p_sel));
      default:
        if (w >= 8 && w < 8 + N_CH)
          m_duty_sh[w-8] = 16'(lane_merge(32'(m_duty_sh[w-8]), p_dat, p_sel));
    endcase
  endfunction

  function automatic logic [N_CH-1:0] model_pwm();
    logic [N_CH-1:0] r;
    longint c;
    c = m_p / (longint'(m_pre) + 1);
    for (int i = 0; i < N_CH; i++)
      r[i] = (m_gen && m_ch_en[i] && (c < longint'(m_duty_act[i]))) ^ m_pol[i];
    return r;
  endfunction

  // Each negedge accounts for the preceding posedge: outputs come from the
  // pre-edge state, then the phase advances, then the write committed there lands.
  always @(negedge clk) begin
    bit wrapped;
    wrapped = 0;
    if (!rst) begin
      model_reset();
      exp_pwm = '0;
    end else begin
      exp_pwm = model_pwm();
      if (!m_gen) begin
        m_p = 0;
        m_per_act = m_per_sh;
        for (int i = 0; i < N_CH; i++) m_duty_act[i] = m_duty_sh[i];
      end else if (m_p == (longint'(m_per_act) + 1) * (longint'(m_pre) + 1) - 1) begin
        m_p = 0;
        m_per_act = m_per_sh;
        for (int i = 0; i < N_CH; i++) m_duty_act[i] = m_duty_sh[i];
        m_wrap = 1;
        wrapped = 1;
        m_wraps++;
      end else begin
        m_p++;
      end
      if (p_valid) begin
        model_apply(wrapped);
        p_valid = 0;
      end
    end
    chk("pwm_o", 32'(pwm_o), 32'(exp_pwm));
    chk("irq", 32'(irq), 32'(m_wrap & m_ie));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int lat;
    @(posedge clk); #1;
    bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_sel_i = s;
    bus.wb_we_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus.wb_ack_o && lat < 8);
    chk("wr_ack_latency", 32'(lat), 32'd1);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    p_addr = a; p_dat = d; p_sel = s; p_valid = 1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    int lat;
    @(posedge clk); #1;
    bus.wb_adr_i = a; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus.wb_ack_o && lat < 8);
    chk("rd_ack_latency", 32'(lat), 32'd1);
    d = bus.wb_dat_o;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    chk(name, d, exp);
  endtask

  task automatic wait_wrap();
    int w0;
    w0 = m_wraps;
    for (int g = 0; g < 400 && m_wraps == w0; g++) tick();
    chk("wrap_wait_timeout", 32'(m_wraps != w0), 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] d;
    logic [11:0] pat12;
    logic [3:0]  ack_pat;
    int ones0, ones1;

    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    model_reset();
    exp_pwm = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;

    // reset state
    chk("reset_pwm", 32'(pwm_o), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_ack", 32'(bus.wb_ack_o), 32'd0);
    chk("reset_dat", bus.wb_dat_o, 32'd0);
    for (int k = 0; k < 6; k++) read_chk("reset_reg", 32'(4 * k), 32'd0);
    for (int k = 0; k < N_CH; k++) read_chk("reset_duty", 32'(32 + 4 * k), 32'd0);
    bus_write(32'h1FC, 32'hFFFF_FFFF, 4'hF);
    read_chk("unmapped_read", 32'h1FC, 32'd0);

    // held strobe: ack must alternate
    @(posedge clk); #1;
    bus.wb_adr_i = 32'h1FC; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    for (int j = 0; j < 4; j++) begin @(posedge clk); #1; ack_pat[j] = bus.wb_ack_o; end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    chk("ack_alternates", 32'(ack_pat), 32'(4'b0101));

    // basic waveform: period 10, duty 3
    bus_write(32'h08, 32'd0, 4'hF);
    bus_write(32'h04, 32'd9, 4'hF);
    bus_write(32'h20, 32'd3, 4'hF);
    bus_write(32'h10, 32'd1, 4'hF);
    bus_write(32'h00, 32'd1, 4'hF);
    pat12 = 12'b1000_0000_1110;
    for (int j = 0; j < 12; j++) begin
      tick();
      chk("t2_shape", 32'(pwm_o[0]), 32'(pat12[j]));
    end
    bus_read(32'h0C, d);
    chk("t2_wrap_set", 32'(d[1:0]), 32'd1);

    // mid-period duty change lands at the next wrap
    wait_wrap();
    bus_write(32'h20, 32'd7, 4'hF);
    bus_read(32'h0C, d);
    chk("t3_pending", 32'(d[1:0]), 32'd3);
    wait_wrap();
    ones0 = 0;
    for (int j = 0; j < 10; j++) begin tick(); ones0 += int'(pwm_o[0]); end
    chk("t3_new_duty", 32'(ones0), 32'd7);
    bus_read(32'h0C, d);
    chk("t3_pend_clear", 32'(d[1:0]), 32'd1);

    // prescaler, inverted polarity, disabled channel
    bus_write(32'h00, 32'd0, 4'hF);
    bus_write(32'h08, 32'd3, 4'hF);
    bus_write(32'h04, 32'd4, 4'hF);
    bus_write(32'h24, 32'd2, 4'hF);
    bus_write(32'h14, 32'd2, 4'hF);
    bus_write(32'h10, 32'd2, 4'hF);
    bus_write(32'h00, 32'd1, 4'hF);
    repeat (3) tick();
    ones0 = 0; ones1 = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      ones0 += int'(pwm_o[0]);
      ones1 += int'(pwm_o[1]);
    end
    chk("t4_ch1_high", 32'(ones1), 32'd12);
    chk("t4_ch0_off", 32'(ones0), 32'd0);

    // 0% and 100% duty, byte lanes
    bus_write(32'h00, 32'd0, 4'hF);
    bus_write(32'h08, 32'd0, 4'hF);
    bus_write(32'h04, 32'd9, 4'hF);
    bus_write(32'h14, 32'd0, 4'hF);
    bus_write(32'h10, 32'hC, 4'hF);
    bus_write(32'h28, 32'd0, 4'hF);
    bus_write(32'h2C, 32'hFFFF, 4'hF);
    bus_write(32'h20, 32'h1234, 4'hF);
    bus_write(32'h20, 32'hAB, 4'b0001);
    read_chk("t5_byte_lane0", 32'h20, 32'h12AB);
    bus_write(32'h20, 32'h00CD_EF00, 4'b0010);
    read_chk("t5_byte_lane1", 32'h20, 32'hEFAB);
    bus_write(32'h00, 32'd1, 4'hF);
    repeat (2) tick();
    ones0 = 0; ones1 = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      ones0 += int'(pwm_o[2]);
      ones1 += int'(pwm_o[3]);
    end
    chk("t5_duty_zero", 32'(ones0), 32'd0);
    chk("t5_duty_full", 32'(ones1), 32'd20);

    // interrupt, clear, and clear colliding with a wrap
    wait_wrap();
    bus_write(32'h00, 32'd3, 4'hF);
    bus_write(32'h0C, 32'd1, 4'hF);
    chk("t6_irq_cleared", 32'(irq), 32'd0);
    wait_wrap();
    chk("t6_irq_on_wrap", 32'(irq), 32'd1);
    bus_write(32'h0C, 32'd1, 4'hF);
    chk("t6_irq_cleared2", 32'(irq), 32'd0);
    wait_wrap();
    repeat (8) @(posedge clk);
    bus_write(32'h0C, 32'd1, 4'hF);
    chk("t6_set_wins_irq", 32'(irq), 32'd1);
    bus_read(32'h0C, d);
    chk("t6_set_wins", 32'(d[0]), 32'd1);

    // asynchronous reset mid-period
    tick();
    chk("t7_before_reset", 32'(pwm_o[3]), 32'd1);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("t7_async_pwm", 32'(pwm_o), 32'd0);
    chk("t7_async_irq", 32'(irq), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    read_chk("t7_duty3", 32'h2C, 32'd0);
    read_chk("t7_ctrl", 32'h00, 32'd0);
    read_chk("t7_status", 32'h0C, 32'd0);
    read_chk("t7_pol", 32'h14, 32'd0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_pwm_multi.md
Name: wb_pwm_multi

Overview:
- Parametrised Wishbone-slave PWM generator; next generation of the fixed 8-output motor PWM peripheral.
- Sits on the conbus at a slave slot, e.g. 0x40000000.
- Adds a configurable channel count, counter width, prescaler and shared period.
- Adds per-channel enable and polarity, glitch-free shadowed duty/period updates at period wrap, and a sticky period-wrap interrupt.

Parameters:
N_CH, 8, number of PWM channels (1..32)
CNT_W, 16, width of the period counter, PERIOD and DUTY registers (2..32)
PRE_W, 8, width of the prescaler counter and PRESCALE register (1..32)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
wb_adr_i  in  32  Wishbone address; word offset taken from bits [7:2]
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, registered
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_sel_i  in  4  byte-lane select for writes
wb_ack_o  out  1  acknowledge
pwm_o  out  N_CH  PWM outputs
irq  out  1  level interrupt: STATUS.WRAP & CTRL.IE

Behaviour:
- Reset (rst=0, asynchronous) clears every register, counter and output to 0: wb_ack_o=0, wb_dat_o=0, pwm_o=0, irq=0.
- Wishbone handshake:
  - wb_ack_o pulses for exactly 1 cycle, in the cycle after cyc&stb is sampled with ack low.
  - ack is never asserted in two consecutive cycles.
  - Write data is committed on the same edge that raises ack; only lanes whose wb_sel_i bit is set are written.
  - wb_dat_o is updated with ack. Unmapped offsets read 0, and writes to them are ignored but still acked.
- Register map (byte offset):
  - 0x00 CTRL: [0] GEN global enable, [1] IE interrupt enable.
  - 0x04 PERIOD_SH [CNT_W-1:0].
  - 0x08 PRESCALE [PRE_W-1:0].
  - 0x0C STATUS: [0] WRAP sticky, write-1-to-clear; [1] PEND (a shadow differs from active, read-only); [31:16] current counter low bits, read-only.
  - 0x10 CH_EN [N_CH-1:0].
  - 0x14 POL [N_CH-1:0], 1 = inverted output.
  - 0x20+4*i DUTY_SH[i] [CNT_W-1:0] for i < N_CH. Reads return the shadow value.
- Prescaler: pre_cnt counts 0..PRESCALE. tick=1 when pre_cnt==PRESCALE, then pre_cnt returns to 0. PRESCALE=0 gives a tick every clock.
- Period counter cnt advances only on tick and wraps to 0 after reaching PERIOD_ACT, giving a period of (PERIOD_ACT+1)*(PRESCALE+1) clocks.
- While GEN=0:
  - cnt=0, pre_cnt=0, WRAP is not set.
  - PERIOD_ACT and DUTY_ACT continuously copy their shadows.
  - pwm_o[i] = POL[i] (idle level).
- GEN 0->1: counting starts on the edge after the write is committed, with cnt=0.
- Wrap event: tick while cnt==PERIOD_ACT.
  - cnt goes to 0.
  - All shadows (PERIOD, every DUTY) load into the active registers atomically on the same edge.
  - WRAP is set.
  - A simultaneous software write-1-to-clear of WRAP loses to the set.
  - A simultaneous shadow write: the new value lands in the shadow only and is applied at the next wrap.
- Output, registered with 1-cycle latency from cnt:
  - raw[i] = GEN & CH_EN[i] & (cnt < DUTY_ACT[i]).
  - pwm_o[i] = raw[i] ^ POL[i].
  - DUTY_ACT=0 gives constant inactive; DUTY_ACT > PERIOD_ACT gives constant active (100%).
- PERIOD_ACT=0 gives a wrap on every tick; output is active iff DUTY_ACT != 0.
- Comparisons are unsigned CNT_W-bit; no overflow paths exist since cnt never exceeds PERIOD_ACT.
- A reset asserted mid-period immediately forces all outputs idle-low (POL is cleared too) and discards pending shadows.

Test Plan:
- Reset, then read all registers -> all 0, pwm_o=0, irq=0; read 0x1FC -> 0 with ack after 1 cycle.
- PRESCALE=0, PERIOD=9, DUTY0=3, CH_EN=1, GEN=1 -> pwm_o[0] high 3 clocks, low 7, repeating every 10 clocks; WRAP sets after the 10th counting clock.
- Same setup, write DUTY0=7 mid-period -> current period keeps 3 high clocks; first period after wrap shows 7 high; STATUS.PEND=1 between the write and the wrap.
- PRESCALE=3, PERIOD=4, DUTY1=2, POL=2, CH_EN=2 -> pwm_o[1] low 8 clocks, high 12 clocks (period 20); pwm_o[0] stays 0.
- DUTY2=0 -> constant inactive; DUTY3=0xFFFF with PERIOD=9 -> constant high; byte write sel=4'b0001 of 0xAB to DUTY0=0x1234 -> shadow reads 0x12AB.
- IE=1: wrap -> irq=1; write STATUS=1 -> irq=0 next cycle; write-clear coinciding with a wrap -> WRAP stays 1; assert rst mid-period -> pwm_o=0 asynchronously, before the next clk edge.
